// File: rtl/toeplitz_pkg.sv
// Shared types and sizing helpers for the Toeplitz hashing block.
package toeplitz_pkg;

  typedef enum logic [2:0] {
    S_LOAD_C,
    S_LOAD_R,
    S_WAIT,
    S_RUN,
    S_OUT
  } state_t;

  localparam int DEF_BS = 64;
  localparam int DEF_N  = 256;
  localparam int DEF_L  = 128;

  localparam int WC = DEF_L / DEF_BS;
  localparam int WR = DEF_N / DEF_BS;

  // Word counter must hold 0..words; bit counter indexes 0..bs-1.
  function automatic int cnt_w(input int words);
    return $clog2(words + 1);
  endfunction

  function automatic int bit_w(input int bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction

endpackage

// File: rtl/toeplitz_hash_ctrl_mac.sv
// Column shift register and GF(2) accumulator; bit L-1-i of col/acc holds row i.
module toeplitz_mac #(
  parameter int L = 128
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         clr,
  input  logic         step,
  input  logic         xbit,
  input  logic         rbit,
  input  logic [L-1:0] cinit,
  output logic [L-1:0] acc
);

  logic [L-1:0] col;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      acc <= '0;
    end else if (load) begin
      col <= cinit;
      acc <= '0;
    end else if (step) begin
      acc <= acc ^ (xbit ? col : '0);
      // next column: row 0 takes the new R bit, every other row moves down one
      col <= L'({rbit, col} >> 1);
    end else if (clr) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/toeplitz_hash_ctrl.sv
// Toeplitz hash sequencer: seed load, bit-serial block hashing, result handshake.
module toeplitz_hash_ctrl
  import toeplitz_pkg::*;
#(
  parameter int BS = DEF_BS,
  parameter int N  = DEF_N,
  parameter int L  = DEF_L
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          reseed,
  input  logic          seed_valid,
  output logic          seed_ready,
  input  logic [BS-1:0] seed_data,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [BS-1:0] din_data,
  output logic          hash_valid,
  input  logic          hash_ready,
  output logic [L-1:0]  hash_data,
  output logic          busy
);

  localparam int NWC = L / BS;
  localparam int NWR = N / BS;
  localparam int CW  = cnt_w(NWR);
  localparam int BW  = bit_w(BS);

  state_t        state, nxt;
  logic [CW-1:0] scnt, wcnt;
  logic [BW-1:0] bcnt;
  logic [L-1:0]  creg;
  logic [N-1:0]  rreg, rsh;
  logic [BS-1:0] xsh;
  logic          din_acc, mac_load, mac_clr, mac_step;
  logic          seed_last, word_last, blk_last;

  assign seed_last = (state == S_LOAD_C) ? (scnt == CW'(NWC - 1)) : (scnt == CW'(NWR - 1));
  assign word_last = (bcnt == BW'(BS - 1));
  assign blk_last  = (wcnt == CW'(NWR - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LOAD_C;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    din_acc  = 1'b0;
    mac_load = 1'b0;
    mac_clr  = 1'b0;
    mac_step = 1'b0;
    case (state)
      S_LOAD_C: if (seed_valid && seed_last) nxt = S_LOAD_R;
      S_LOAD_R: if (seed_valid && seed_last) nxt = S_WAIT;
      S_WAIT: begin
        // reseed wins only between blocks
        if (reseed && wcnt == '0) begin
          nxt = S_LOAD_C;
        end else if (din_valid) begin
          nxt      = S_RUN;
          din_acc  = 1'b1;
          mac_load = (wcnt == '0);
        end
      end
      S_RUN: begin
        mac_step = 1'b1;
        if (word_last) nxt = blk_last ? S_OUT : S_WAIT;
      end
      S_OUT: begin
        if (hash_ready) begin
          nxt     = S_WAIT;
          mac_clr = 1'b1;
        end
      end
      default: nxt = S_LOAD_C;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scnt <= '0;
      wcnt <= '0;
      bcnt <= '0;
      creg <= '0;
      rreg <= '0;
      rsh  <= '0;
      xsh  <= '0;
    end else begin
      case (state)
        S_LOAD_C: if (seed_valid) begin
          creg <= L'({creg, seed_data});
          scnt <= seed_last ? '0 : scnt + 1'b1;
        end
        S_LOAD_R: if (seed_valid) begin
          rreg <= N'({rreg, seed_data});
          scnt <= seed_last ? '0 : scnt + 1'b1;
        end
        S_WAIT: if (din_acc) begin
          xsh  <= din_data;
          bcnt <= '0;
          // MSB of rsh is always R[j+1] for the bit being processed
          if (wcnt == '0) rsh <= rreg << 1;
        end
        S_RUN: begin
          xsh  <= xsh << 1;
          rsh  <= rsh << 1;
          bcnt <= bcnt + 1'b1;
          if (word_last) begin
            bcnt <= '0;
            if (!blk_last) wcnt <= wcnt + 1'b1;
          end
        end
        S_OUT: if (hash_ready) wcnt <= '0;
        default: ;
      endcase
    end
  end

  toeplitz_mac #(.L(L)) u_mac (
    .clk   (clk),
    .rstn  (rstn),
    .load  (mac_load),
    .clr   (mac_clr),
    .step  (mac_step),
    .xbit  (xsh[BS-1]),
    .rbit  (rsh[N-1]),
    .cinit (creg),
    .acc   (hash_data)
  );

  assign seed_ready = (state == S_LOAD_C) || (state == S_LOAD_R);
  assign din_ready  = (state == S_WAIT);
  assign hash_valid = (state == S_OUT);
  assign busy       = (state == S_RUN) || (state == S_OUT) || (wcnt != '0);

endmodule

// File: tb/tb_toeplitz_hash_ctrl.sv
// Bench: small (BS=4,N=8,L=4) and default instances checked against a matrix-level GF(2) model.
module tb_toeplitz_hash_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic s_reseed, s_sv, s_sr, s_dv, s_dr, s_hv, s_hr, s_busy;
  logic [3:0] s_sd, s_dd, s_hd;
  logic d_reseed, d_sv, d_sr, d_dv, d_dr, d_hv, d_hr, d_busy;
  logic [63:0] d_sd, d_dd;
  logic [127:0] d_hd;

  toeplitz_hash_ctrl #(.BS(4), .N(8), .L(4)) u_small (
    .clk(clk), .rstn(rstn), .reseed(s_reseed),
    .seed_valid(s_sv), .seed_ready(s_sr), .seed_data(s_sd),
    .din_valid(s_dv), .din_ready(s_dr), .din_data(s_dd),
    .hash_valid(s_hv), .hash_ready(s_hr), .hash_data(s_hd), .busy(s_busy)
  );

  toeplitz_hash_ctrl u_dut (
    .clk(clk), .rstn(rstn), .reseed(d_reseed),
    .seed_valid(d_sv), .seed_ready(d_sr), .seed_data(d_sd),
    .din_valid(d_dv), .din_ready(d_dr), .din_data(d_dd),
    .hash_valid(d_hv), .hash_ready(d_hr), .hash_data(d_hd), .busy(d_busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // y = T x over GF(2), T[i][j] = c[i-j] below/on the diagonal, r[j-i] above it
  function automatic logic [127:0] ref_hash(input int bs, input int n, input int l,
      input logic [63:0] cw[$], input logic [63:0] rw[$], input logic [63:0] xw[$]);
    bit c[256], r[256], x[256];
    logic [63:0] w;
    logic [127:0] h;
    bit y;
    h = '0;
    for (int m = 0; m < n; m++) begin
      w = rw[m / bs]; r[m] = w[bs - 1 - m % bs];
      w = xw[m / bs]; x[m] = w[bs - 1 - m % bs];
      if (m < l) begin w = cw[m / bs]; c[m] = w[bs - 1 - m % bs]; end
    end
    for (int i = 0; i < l; i++) begin
      y = 1'b0;
      for (int j = 0; j < n; j++)
        if (x[j]) y ^= (i >= j) ? c[i - j] : r[j - i];
      h[l - 1 - i] = y;
    end
    return h;
  endfunction

  task automatic idle_inputs();
    s_reseed = 0; s_sv = 0; s_dv = 0; s_hr = 0; s_sd = '0; s_dd = '0;
    d_reseed = 0; d_sv = 0; d_dv = 0; d_hr = 0; d_sd = '0; d_dd = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_seed(input bit big, input logic [63:0] w, input int gmax);
    bit rdy;
    int t;
    t = 0;
    repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
    if (big) begin d_sv = 1; d_sd = w; end else begin s_sv = 1; s_sd = w[3:0]; end
    do begin
      @(negedge clk); rdy = big ? d_sr : s_sr;
      @(posedge clk); #1; t++;
    end while (!rdy && t < 300);
    if (!rdy) begin n_cmp++; n_fail++; $display("FAIL seed_accept timeout big=%0d", big); end
    d_sv = 0; s_sv = 0;
  endtask

  task automatic push_din(input bit big, input logic [63:0] w, input int gmax);
    bit rdy;
    int t;
    t = 0;
    repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
    if (big) begin d_dv = 1; d_dd = w; end else begin s_dv = 1; s_dd = w[3:0]; end
    do begin
      @(negedge clk); rdy = big ? d_dr : s_dr;
      @(posedge clk); #1; t++;
    end while (!rdy && t < 300);
    if (!rdy) begin n_cmp++; n_fail++; $display("FAIL din_accept timeout big=%0d", big); end
    d_dv = 0; s_dv = 0;
  endtask

  // Waits for hash_valid, holds hash_ready low for 'gaps' cycles checking stability, then takes it.
  task automatic pull_hash(input bit big, input int gaps, output logic [127:0] h, output int vcyc);
    bit v;
    int t;
    logic [127:0] cur;
    t = 0;
    h = 'x;
    vcyc = -1;
    forever begin
      @(negedge clk); v = big ? d_hv : s_hv;
      if (v || t >= 400) break;
      t++;
    end
    if (!v) begin
      n_cmp++; n_fail++; $display("FAIL hash_valid timeout big=%0d", big);
      @(posedge clk); #1;
      return;
    end
    vcyc = cyc;
    h = big ? d_hd : {124'b0, s_hd};
    repeat (gaps) begin
      @(negedge clk);
      cur = big ? d_hd : {124'b0, s_hd};
      v = big ? d_hv : s_hv;
      n_cmp++;
      if (cur !== h || v !== 1'b1) begin
        n_fail++; $display("FAIL hash_stable big=%0d got=%h valid=%b want=%h", big, cur, v, h);
      end
    end
    if (big) d_hr = 1; else s_hr = 1;
    @(posedge clk); #1;
    d_hr = 0; s_hr = 0;
    v = big ? d_hv : s_hv;
    n_cmp++;
    if (v !== 1'b0) begin n_fail++; $display("FAIL hash_valid_drop big=%0d got=%b want=0", big, v); end
  endtask

  task automatic load_small(input logic [63:0] cw[$], input logic [63:0] rw[$]);
    foreach (cw[k]) push_seed(0, cw[k], 0);
    foreach (rw[k]) push_seed(0, rw[k], 0);
  endtask

  task automatic small_block(input string name, input logic [63:0] cw[$], input logic [63:0] rw[$],
      input logic [63:0] xw[$], input logic [3:0] want);
    logic [127:0] h, m;
    int vc;
    foreach (xw[k]) push_din(0, xw[k], 0);
    pull_hash(0, 1, h, vc);
    m = ref_hash(4, 8, 4, cw, rw, xw);
    n_cmp++;
    if (h[3:0] !== want || m[3:0] !== want) begin
      n_fail++; $display("FAIL %s got=%h model=%h want=%h", name, h[3:0], m[3:0], want);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #3;
    n_cmp++;
    if ({s_sr, s_dr, s_hv, s_busy} !== 4'b1000 || s_hd !== 4'h0) begin
      n_fail++; $display("FAIL reset_small got=%b/%h want=1000/0", {s_sr, s_dr, s_hv, s_busy}, s_hd);
    end
    n_cmp++;
    if ({d_sr, d_dr, d_hv, d_busy} !== 4'b1000 || d_hd !== '0) begin
      n_fail++; $display("FAIL reset_dflt got=%b/%h want=1000/0", {d_sr, d_dr, d_hv, d_busy}, d_hd);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({s_sr, s_dr, s_hv, s_busy} !== 4'b1000) begin
      n_fail++; $display("FAIL post_reset_small got=%b want=1000", {s_sr, s_dr, s_hv, s_busy});
    end
  endtask

  task automatic test_identity();
    logic [63:0] cw[$], rw[$];
    logic [127:0] h;
    int t0, vc;
    apply_reset();
    cw = '{64'h8}; rw = '{64'h0, 64'h0};
    load_small(cw, rw);
    push_din(0, 64'hA, 0);
    t0 = cyc;
    push_din(0, 64'h5, 0);
    pull_hash(0, 2, h, vc);
    n_cmp++;
    if (h[3:0] !== 4'hA) begin n_fail++; $display("FAIL identity got=%h want=a", h[3:0]); end
    n_cmp++;
    if (vc - t0 !== 9) begin n_fail++; $display("FAIL identity_latency got=%0d want=9", vc - t0); end
  endtask

  task automatic test_all_ones();
    logic [63:0] cw[$], rw[$];
    apply_reset();
    cw = '{64'hF}; rw = '{64'hF, 64'hF};
    load_small(cw, rw);
    small_block("ones_parity1", cw, rw, '{64'h0, 64'h7}, 4'hF);
    small_block("ones_parity0", cw, rw, '{64'h3, 64'h0}, 4'h0);
  endtask

  task automatic test_wrong_state();
    logic [63:0] cw[$], rw[$];
    apply_reset();
    cw = '{64'h8}; rw = '{64'h0, 64'h0};
    s_dv = 1; s_dd = 4'hF;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (s_dr !== 1'b0 || s_busy !== 1'b0) begin
        n_fail++; $display("FAIL din_in_load_c ready=%b busy=%b want=0/0", s_dr, s_busy);
      end
    end
    @(posedge clk); #1;
    push_seed(0, cw[0], 0);
    @(negedge clk);
    n_cmp++;
    if (s_dr !== 1'b0) begin n_fail++; $display("FAIL din_in_load_r ready=%b want=0", s_dr); end
    @(posedge clk); #1;
    s_dv = 0;
    push_seed(0, rw[0], 0);
    push_seed(0, rw[1], 0);
    @(negedge clk);
    n_cmp++;
    if (s_busy !== 1'b0 || s_dr !== 1'b1) begin
      n_fail++; $display("FAIL wait_clean busy=%b ready=%b want=0/1", s_busy, s_dr);
    end
    @(posedge clk); #1;
    small_block("after_wrong_state", cw, rw, '{64'hA, 64'h5}, 4'hA);
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] cw[$], rw[$];
    apply_reset();
    load_small('{64'h8}, '{64'h0, 64'h0});
    push_din(0, 64'h3, 0);
    @(posedge clk); #1;
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({s_sr, s_dr, s_hv, s_busy} !== 4'b1000 || s_hd !== 4'h0) begin
      n_fail++; $display("FAIL reset_mid_run got=%b/%h want=1000/0", {s_sr, s_dr, s_hv, s_busy}, s_hd);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    cw = '{64'hF}; rw = '{64'hF, 64'hF};
    load_small(cw, rw);
    small_block("new_seed_after_reset", cw, rw, '{64'h3, 64'h0}, 4'h0);
  endtask

  task automatic test_reseed();
    logic [63:0] cw[$], rw[$], xw[$];
    logic [127:0] h, m;
    int vc, t;
    apply_reset();
    cw = '{64'h8}; rw = '{64'h0, 64'h0}; xw = '{64'h9, 64'h6};
    load_small(cw, rw);
    push_din(0, xw[0], 0);
    s_reseed = 1;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (s_sr !== 1'b0) begin n_fail++; $display("FAIL reseed_run_or_partial seed_ready=%b want=0", s_sr); end
    end
    @(posedge clk); #1;
    s_reseed = 0;
    push_din(0, xw[1], 0);
    t = 0;
    do begin @(negedge clk); t++; end while (s_hv !== 1'b1 && t < 100);
    s_reseed = 1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (s_sr !== 1'b0 || s_hv !== 1'b1) begin
        n_fail++; $display("FAIL reseed_out seed_ready=%b valid=%b want=0/1", s_sr, s_hv);
      end
    end
    s_reseed = 0;
    pull_hash(0, 0, h, vc);
    m = ref_hash(4, 8, 4, cw, rw, xw);
    n_cmp++;
    if (h[3:0] !== 4'h9 || m[3:0] !== 4'h9) begin
      n_fail++; $display("FAIL reseed_block got=%h model=%h want=9", h[3:0], m[3:0]);
    end
    s_reseed = 1;
    @(posedge clk); #1;
    s_reseed = 0;
    @(negedge clk);
    n_cmp++;
    if (s_sr !== 1'b1 || s_dr !== 1'b0) begin
      n_fail++; $display("FAIL reseed_idle seed_ready=%b din_ready=%b want=1/0", s_sr, s_dr);
    end
    @(posedge clk); #1;
    cw = '{64'hF}; rw = '{64'hF, 64'hF};
    load_small(cw, rw);
    small_block("reseeded_block", cw, rw, '{64'h1, 64'h0}, 4'hF);
  endtask

  task automatic test_random_blocks();
    logic [63:0] cw[$], rw[$], xw[$];
    logic [127:0] h, m;
    int vc;
    apply_reset();
    for (int k = 0; k < 2; k++) cw.push_back({$urandom, $urandom});
    for (int k = 0; k < 4; k++) rw.push_back({$urandom, $urandom});
    foreach (cw[k]) push_seed(1, cw[k], 3);
    foreach (rw[k]) push_seed(1, rw[k], 3);
    for (int b = 0; b < 20; b++) begin
      xw.delete();
      for (int k = 0; k < 4; k++) xw.push_back({$urandom, $urandom});
      foreach (xw[k]) push_din(1, xw[k], 3);
      pull_hash(1, $urandom_range(0, 3), h, vc);
      m = ref_hash(64, 256, 128, cw, rw, xw);
      n_cmp++;
      if (h !== m) begin n_fail++; $display("FAIL random_block%0d got=%h want=%h", b, h, m); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_identity();
    test_all_ones();
    test_wrong_state();
    test_reset_mid_run();
    test_reseed();
    test_random_blocks();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
